// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register-group offsets and sizing limits.
// Offsets are 6-bit region offsets; bits [5:3] select the group, [2:0] the port.
package gpio_pkg;
    localparam int NPORT_MAX  = 8;
    localparam int ARM_CYCLES = 3;

    localparam logic [5:0] OFF_OUT  = 6'h00;
    localparam logic [5:0] OFF_DIR  = 6'h08;
    localparam logic [5:0] OFF_IN   = 6'h10;
    localparam logic [5:0] OFF_MASK = 6'h18;
    localparam logic [5:0] OFF_STAT = 6'h20;
endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs, parametrised width.
// Latency 2 cycles; no backpressure (free-running).
module gpio_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/gpio_bank.sv
// Register-mapped GPIO bank: OUT/DIR/IN per port, plus MASK/STAT edge interrupts when GPIO_IRQ_EN is defined.
// Read latency 1 cycle (dout/dout_valid registered); writes land on the strobe edge; no backpressure.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int         NPORT = 8,
    parameter int         W     = 8,
    parameter logic [7:0] BASE  = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         addr,
    input  logic [W-1:0]       din,
    input  logic               re,
    input  logic               we,
    output logic [W-1:0]       dout,
    output logic               dout_valid,
    output logic               io_read,
    output logic               io_write,
    output logic [NPORT*W-1:0] io_o,
    output logic [NPORT*W-1:0] io_oe,
    input  logic [NPORT*W-1:0] io_i,
    output logic               irq
);
    typedef logic [NPORT-1:0][W-1:0] bank_t;

    logic       hit, port_ok;
    logic [2:0] grp, idx;
    logic [5:0] grp_off;
    logic       wr_sel;

    bank_t out_d, out_q;
    bank_t dir_d, dir_q;
    bank_t in_sync;

    logic [W-1:0] rd_val;
    logic [W-1:0] dout_d, dout_q;
    logic         dout_valid_d, dout_valid_q;

    assign hit      = (addr[7:6] == BASE[7:6]);
    assign grp      = addr[5:3];
    assign idx      = addr[2:0];
    assign grp_off  = {grp, 3'b000};
    assign port_ok  = (int'(idx) < NPORT);
    assign io_read  = re & hit;
    assign io_write = we & hit;
    assign wr_sel   = io_write & port_ok;

    for (genvar n = 0; n < NPORT; n++) begin : g_sync
        gpio_sync #(.W(W)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (io_i[n*W +: W]),
            .q     (in_sync[n])
        );
    end

`ifdef GPIO_IRQ_EN
    bank_t       mask_d, mask_q;
    bank_t       stat_d, stat_q;
    bank_t       prev_d, prev_q;
    logic [1:0]  arm_d, arm_q;
    logic        armed;

    // Pins already high at reset reach prev_q before arming completes, so they never look like edges.
    assign armed = (arm_q == 2'(ARM_CYCLES));

    always_comb begin
        arm_d  = armed ? arm_q : arm_q + 2'd1;
        prev_d = in_sync;
        mask_d = mask_q;
        stat_d = stat_q;
        if (wr_sel && grp_off == OFF_MASK) mask_d[idx] = din;
        if (wr_sel && grp_off == OFF_STAT) stat_d[idx] = stat_q[idx] & ~din;
        if (armed) stat_d = stat_d | (in_sync & ~prev_q & mask_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q  <= '0;
            prev_q <= '0;
            mask_q <= '0;
            stat_q <= '0;
        end else begin
            arm_q  <= arm_d;
            prev_q <= prev_d;
            mask_q <= mask_d;
            stat_q <= stat_d;
        end
    end

    assign irq = |stat_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        if (port_ok) begin
            case (grp_off)
                OFF_OUT:  rd_val = out_q[idx];
                OFF_DIR:  rd_val = dir_q[idx];
                OFF_IN:   rd_val = in_sync[idx];
`ifdef GPIO_IRQ_EN
                OFF_MASK: rd_val = mask_q[idx];
                OFF_STAT: rd_val = stat_q[idx];
`endif
                default:  rd_val = '0;
            endcase
        end
    end

    // Read mux sees pre-edge state, so a same-cycle write is not visible to the read.
    always_comb begin
        out_d        = out_q;
        dir_d        = dir_q;
        if (wr_sel && grp_off == OFF_OUT) out_d[idx] = din;
        if (wr_sel && grp_off == OFF_DIR) dir_d[idx] = din;
        dout_d       = io_read ? rd_val : dout_q;
        dout_valid_d = io_read;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            dir_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            dir_q        <= dir_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign io_o       = out_q;
    assign io_oe      = dir_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank (NPORT=8, W=8); interrupt scenarios follow GPIO_IRQ_EN.
module tb_gpio_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic [7:0]  din = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        io_read;
    logic        io_write;
    logic [63:0] io_o;
    logic [63:0] io_oe;
    logic [63:0] io_i = '0;
    logic        irq;

    int total = 0;
    int bad   = 0;

    gpio_bank #(.NPORT(8), .W(8), .BASE(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .din        (din),
        .re         (re),
        .we         (we),
        .dout       (dout),
        .dout_valid (dout_valid),
        .io_read    (io_read),
        .io_write   (io_write),
        .io_o       (io_o),
        .io_oe      (io_oe),
        .io_i       (io_i),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; we = 1'b1;
        cycle();
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic v);
        addr = a; re = 1'b1;
        cycle();
        d = dout; v = dout_valid;
        re = 1'b0;
    endtask

    task automatic test_reset();
        io_i  = '1;
        rst_n = 1'b0;
        cycle(); cycle();
        total++; if (dout !== 8'h00)    begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        total++; if (io_oe !== 64'h0)   begin bad++; $display("FAIL reset_io_oe got=%h exp=0", io_oe); end
        total++; if (io_o !== 64'h0)    begin bad++; $display("FAIL reset_io_o got=%h exp=0", io_o); end
        total++; if (irq !== 1'b0)      begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_no_spurious();
        logic [7:0] d; logic v;
        for (int p = 0; p < 8; p++) wr(8'h18 + 8'(p), 8'hFF);
        repeat (5) cycle();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL hi_at_reset_irq got=%b exp=0", irq); end
        rd(8'h22, d, v);
        total++; if (d !== 8'h00 || v !== 1'b1) begin bad++; $display("FAIL hi_at_reset_stat got=%h/%b exp=00/1", d, v); end
        rd(8'h2A, d, v);
        total++; if (d !== 8'h00 || v !== 1'b1) begin bad++; $display("FAIL read_2a got=%h/%b exp=00/1", d, v); end
        addr = 8'h40; re = 1'b1;
        #1;
        total++; if (io_read !== 1'b0) begin bad++; $display("FAIL miss_io_read got=%b exp=0", io_read); end
        cycle();
        re = 1'b0;
        total++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin bad++; $display("FAIL miss_read got=%h/%b exp=00/0", dout, dout_valid); end
        for (int p = 0; p < 8; p++) wr(8'h18 + 8'(p), 8'h00);
        io_i = '0;
        repeat (4) cycle();
    endtask

    task automatic test_write_read();
        logic [7:0] d; logic v;
        wr(8'h03, 8'hA5);
        total++; if (io_o[31:24] !== 8'hA5) begin bad++; $display("FAIL out3_pin got=%h exp=a5", io_o[31:24]); end
        total++; if (io_o[23:0] !== 24'h0 || io_o[63:32] !== 32'h0) begin bad++; $display("FAIL out_other_pins got=%h exp=00000000a5000000", io_o); end
        addr = 8'h03; re = 1'b1;
        #1;
        total++; if (io_read !== 1'b1) begin bad++; $display("FAIL hit_io_read got=%b exp=1", io_read); end
        cycle();
        re = 1'b0;
        total++; if (dout !== 8'hA5 || dout_valid !== 1'b1) begin bad++; $display("FAIL read_out3 got=%h/%b exp=a5/1", dout, dout_valid); end
        cycle();
        total++; if (dout !== 8'hA5 || dout_valid !== 1'b0) begin bad++; $display("FAIL dout_hold got=%h/%b exp=a5/0", dout, dout_valid); end
        wr(8'h28, 8'hFF);
        rd(8'h28, d, v);
        total++; if (d !== 8'h00 || io_o !== 64'h00000000A5000000 || io_oe !== 64'h0) begin bad++; $display("FAIL write_28_ignored got=%h exp=00", d); end
    endtask

    task automatic test_loopback();
        logic [7:0] d; logic v;
        wr(8'h09, 8'hFF);
        wr(8'h01, 8'h3C);
        total++; if (io_oe[15:8] !== 8'hFF || io_o[15:8] !== 8'h3C) begin bad++; $display("FAIL dir1_out1 got=%h/%h exp=ff/3c", io_oe[15:8], io_o[15:8]); end
        io_i[15:8] = io_o[15:8];
        repeat (3) cycle();
        rd(8'h11, d, v);
        total++; if (d !== 8'h3C || v !== 1'b1) begin bad++; $display("FAIL in1_loopback got=%h/%b exp=3c/1", d, v); end
    endtask

    task automatic test_same_cycle_rw();
        logic [7:0] d; logic v;
        wr(8'h05, 8'h11);
        addr = 8'h05; din = 8'h22; re = 1'b1; we = 1'b1;
        cycle();
        re = 1'b0; we = 1'b0;
        total++; if (dout !== 8'h11) begin bad++; $display("FAIL rw_pre_value got=%h exp=11", dout); end
        rd(8'h05, d, v);
        total++; if (d !== 8'h22) begin bad++; $display("FAIL rw_write_took got=%h exp=22", d); end
    endtask

`ifdef GPIO_IRQ_EN
    task automatic test_irq();
        logic [7:0] d; logic v;
        int n;
        wr(8'h1A, 8'h01);
        io_i[16] = 1'b1;
        n = 0;
        while (irq !== 1'b1 && n < 3) begin cycle(); n++; end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1 within 3", irq); end
        rd(8'h22, d, v);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL stat2_set got=%h exp=01", d); end
        wr(8'h22, 8'h01);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b exp=0", irq); end
        rd(8'h22, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL stat2_cleared got=%h exp=00", d); end
    endtask

    task automatic test_w1c_race();
        logic [7:0] d; logic v;
        io_i[16] = 1'b0; repeat (3) cycle();
        io_i[16] = 1'b1; repeat (4) cycle();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL race_setup_irq got=%b exp=1", irq); end
        io_i[16] = 1'b0; repeat (3) cycle();
        io_i[16] = 1'b1;
        cycle(); cycle();
        wr(8'h22, 8'h01);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL race_irq got=%b exp=1", irq); end
        rd(8'h22, d, v);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL race_stat got=%h exp=01", d); end
    endtask

    task automatic test_mask_clear();
        logic [7:0] d; logic v;
        wr(8'h1A, 8'h00);
        rd(8'h22, d, v);
        total++; if (d !== 8'h01 || irq !== 1'b1) begin bad++; $display("FAIL mask_clear_keeps got=%h/%b exp=01/1", d, irq); end
        wr(8'h22, 8'h01);
        io_i[16] = 1'b0; repeat (3) cycle();
        io_i[16] = 1'b1; repeat (4) cycle();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL masked_edge got=%b exp=0", irq); end
    endtask
`else
    task automatic test_irq_absent();
        logic [7:0] d; logic v;
        wr(8'h1A, 8'hFF);
        rd(8'h1A, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mask_absent got=%h exp=00", d); end
        io_i[16] = 1'b1; repeat (5) cycle();
        rd(8'h22, d, v);
        total++; if (d !== 8'h00 || irq !== 1'b0) begin bad++; $display("FAIL stat_absent got=%h/%b exp=00/0", d, irq); end
    endtask
`endif

    task automatic test_reset_midread();
        addr = 8'h03; re = 1'b1;
        #3;
        rst_n = 1'b0;
        cycle();
        re = 1'b0;
        total++; if (dout_valid !== 1'b0 || dout !== 8'h00) begin bad++; $display("FAIL midread_reset got=%h/%b exp=00/0", dout, dout_valid); end
        total++; if (io_o !== 64'h0 || io_oe !== 64'h0 || irq !== 1'b0) begin bad++; $display("FAIL midread_state got=%h/%h/%b exp=0/0/0", io_o, io_oe, irq); end
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_no_spurious();
        test_write_read();
        test_loopback();
        test_same_cycle_rw();
`ifdef GPIO_IRQ_EN
        test_irq();
        test_w1c_race();
        test_mask_clear();
`else
        test_irq_absent();
`endif
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
